fpu_fma_issue: RTL and testbench

Issue/response controller directly upstream of the fused multiply-add unit (fpu_fma).
- Accepts one R4-type FP request over a valid/ready handshake.
- Resolves the dynamic rounding mode against fcsr.frm and rejects illegal modes.
- Holds operands stable, pulses the FMA start, and waits for done with a timeout guard.
- Returns result, destination index and fflags over a valid/ready response port, and keeps a sticky fflags accumulator for the CSR file.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_rm_resolve.sv | 18 +
 rtl/fpu_fma_issue.sv | 154 +++++++++++++++
 tb/tb_fpu_fma_issue.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the FP issue/response controllers.
//   - Rounding-mode encodings (fcsr.frm / instruction rm field)
//   - FMA opcode enum
//   - fflags bit positions
//   - Canonical quiet NaN
//   - rm_is_legal(): true for the five defined rounding modes
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'b00,
    OP_FMSUB  = 2'b01,
    OP_FNMSUB = 2'b10,
    OP_FNMADD = 2'b11
  } fma_op_t;

  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Encodings 101 and 110 are reserved; 111 is only meaningful in the
  // instruction field and is illegal once resolved.
  function automatic logic rm_is_legal(input logic [2:0] rm);
    return rm <= RM_RMM;
  endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Rounding-mode resolver shared by the FP issue paths.
//   rm      : instruction rounding-mode field (111 = dynamic)
//   csr_frm : current fcsr.frm
//   eff_rm  : rounding mode the datapath should use
//   illegal : eff_rm is a reserved encoding; the op must not execute
module fpu_rm_resolve
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic [2:0] csr_frm,
  output logic [2:0] eff_rm,
  output logic       illegal
);

  assign eff_rm  = (rm == RM_DYN) ? csr_frm : rm;
  assign illegal = !rm_is_legal(eff_rm);

endmodule

// File: rtl/fpu_fma_issue.sv
// Issue/response controller in front of the fused multiply-add unit.
// One request in flight: accept over req_valid/req_ready, resolve the
// rounding mode, pulse fma_start, wait for fma_done (with a timeout), then
// present the result on resp_valid/resp_ready. A sticky fflags accumulator
// collects flags of completed, legal operations for the CSR file.
//   req_*    : request handshake, operands, opcode, rm, destination tag
//   csr_frm  : fcsr.frm used when req_rm is dynamic
//   fma_*    : operands/opcode/rm held stable to the FMA, start pulse out,
//              result, inexact flag and done pulse back
//   resp_*   : response handshake, result, tag, fflags, illegal/timeout
//   fflags_* : sticky accumulator and its clear
module fpu_fma_issue
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [31:0]      req_rs3,
  input  logic [1:0]       req_opcode,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       csr_frm,
  output logic             fma_start,
  output logic [31:0]      fma_rs1,
  output logic [31:0]      fma_rs2,
  output logic [31:0]      fma_rs3,
  output logic [1:0]       fma_opcode,
  output logic [2:0]       fma_frm,
  input  logic [31:0]      fma_rd,
  input  logic             fma_flag_nx,
  input  logic             fma_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic [4:0]       resp_fflags,
  output logic             resp_illegal,
  output logic             resp_timeout,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  fma_op_t          op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       eff_rm;
  logic             rm_illegal;
  logic             resp_hs;
  logic [4:0]       acc_add;

  fpu_rm_resolve u_rm_resolve (
    .rm      (req_rm),
    .csr_frm (csr_frm),
    .eff_rm  (eff_rm),
    .illegal (rm_illegal)
  );

  // Handshake strobes decode straight from the state register, so reset
  // drops fma_start and resp_valid without waiting for a clock edge.
  assign req_ready  = (state == IDLE);
  assign fma_start  = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign fma_opcode = op_q;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: operand and response registers are reset too; they drive module
      // outputs that must read 0 straight out of reset.
      state        <= IDLE;
      op_q         <= OP_FMADD;
      fma_rs1      <= '0;
      fma_rs2      <= '0;
      fma_rs3      <= '0;
      fma_frm      <= '0;
      wait_cnt     <= '0;
      resp_result  <= '0;
      resp_tag     <= '0;
      resp_fflags  <= '0;
      resp_illegal <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            fma_rs1      <= req_rs1;
            fma_rs2      <= req_rs2;
            fma_rs3      <= req_rs3;
            op_q         <= fma_op_t'(req_opcode);
            resp_tag     <= req_tag;
            resp_timeout <= 1'b0;
            if (rm_illegal) begin
              // Reserved rounding mode: answer immediately, FMA untouched.
              resp_illegal <= 1'b1;
              resp_result  <= '0;
              resp_fflags  <= '0;
              state        <= RESP;
            end else begin
              resp_illegal <= 1'b0;
              fma_frm      <= eff_rm;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (fma_done) begin
            resp_result <= fma_rd;
            resp_fflags <= {4'b0000, fma_flag_nx};
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            resp_result  <= CANON_NAN;
            resp_fflags  <= '0;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Illegal and timed-out responses carry no architectural flags. A clear
  // coinciding with a handshake keeps only the new flags.
  assign resp_hs = resp_valid && resp_ready;
  assign acc_add = (resp_hs && !resp_illegal && !resp_timeout) ? resp_fflags : 5'b00000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fflags_acc <= '0;
    else      fflags_acc <= (fflags_clr ? 5'b00000 : fflags_acc) | acc_add;
  end

endmodule

// File: tb/tb_fpu_fma_issue.sv
// Scoreboard testbench for fpu_fma_issue. Stimulus pushes the expected
// response; a negedge monitor pops and compares whenever resp_valid shows,
// keeps its own sticky-flag model, and checks req_ready stays low while a
// response is pending. A behavioural FMA stub answers fma_start.
module tb_fpu_fma_issue;

  localparam int TO = 16;
  localparam int TW = 5;
  localparam logic [31:0] NAN = 32'h7FC0_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic [1:0]    req_opcode = '0;
  logic [2:0]    req_rm = '0;
  logic [TW-1:0] req_tag = '0;
  logic [2:0]    csr_frm = '0;
  logic          fma_start;
  logic [31:0]   fma_rs1, fma_rs2, fma_rs3;
  logic [1:0]    fma_opcode;
  logic [2:0]    fma_frm;
  logic [31:0]   fma_rd = '0;
  logic          fma_flag_nx = 1'b0;
  logic          fma_done = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_result;
  logic [TW-1:0] resp_tag;
  logic [4:0]    resp_fflags;
  logic          resp_illegal;
  logic          resp_timeout;
  logic [4:0]    fflags_acc;
  logic          fflags_clr = 1'b0;

  fpu_fma_issue #(.TIMEOUT_CYCLES(TO), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_opcode(req_opcode), .req_rm(req_rm), .req_tag(req_tag),
    .csr_frm(csr_frm),
    .fma_start(fma_start),
    .fma_rs1(fma_rs1), .fma_rs2(fma_rs2), .fma_rs3(fma_rs3),
    .fma_opcode(fma_opcode), .fma_frm(fma_frm),
    .fma_rd(fma_rd), .fma_flag_nx(fma_flag_nx), .fma_done(fma_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .resp_fflags(resp_fflags),
    .resp_illegal(resp_illegal), .resp_timeout(resp_timeout),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   result;
    logic [TW-1:0] tag;
    logic [4:0]    fflags;
    logic          illegal;
    logic          timeout;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  bit         in_resp = 0;
  logic [4:0] acc_model = '0;
  int         checks = 0;
  int         errors = 0;
  int         starts = 0;
  int         exp_starts = 0;
  bit         last_ill = 0;

  // Stub controls for the operation currently being issued.
  bit         stub_hang = 0;
  int         stub_lat = 1;
  bit         stub_nx = 0;
  logic [2:0] stub_frm = '0;
  bit         stub_busy = 0;
  int         stub_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in FMA: the known vector 1.5*2.0+1.0 returns 4.0; anything else
  // returns a mix of all inputs so wrong operands, opcode or rm show up.
  function automatic logic [31:0] fma_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [1:0] op,
                                            input logic [2:0] rm);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000 && c == 32'h3F80_0000 && op == 2'b00)
      return 32'h4080_0000;
    return (a * 32'h9E37_79B1) ^ {b[15:0], b[31:16]} ^ (c + {27'd0, op, rm});
  endfunction

  // FMA stub: answers after stub_lat cycles, never in hang mode (a late done
  // arrives after the timeout), and throws stray done pulses while idle.
  initial begin
    forever begin
      @(posedge clk); #1;
      fma_done    = 1'b0;
      fma_flag_nx = 1'b0;
      if (!rst) begin
        stub_busy = 0;
      end else if (fma_start) begin
        stub_busy = 1;
        stub_cnt  = 0;
        check("fma_frm_at_start", 32'(fma_frm), 32'(stub_frm));
      end else if (stub_busy) begin
        stub_cnt++;
        if (!stub_hang && stub_cnt == stub_lat) begin
          check("fma_frm_at_done", 32'(fma_frm), 32'(stub_frm));
          fma_rd      = fma_model(fma_rs1, fma_rs2, fma_rs3, fma_opcode, fma_frm);
          fma_flag_nx = stub_nx;
          fma_done    = 1'b1;
          stub_busy   = 0;
        end else if (stub_hang && stub_cnt == TO + 3) begin
          fma_rd      = $urandom;
          fma_flag_nx = 1'b1;
          fma_done    = 1'b1;
          stub_busy   = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        fma_rd      = $urandom;
        fma_flag_nx = 1'b1;
        fma_done    = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      acc_model = '0;
      in_resp   = 0;
    end else begin
      check("fflags_acc", 32'(fflags_acc), 32'(acc_model));
      if (fma_start) starts++;
      if (resp_valid) begin
        check("req_ready_during_resp", 32'(req_ready), 32'd0);
        if (!in_resp) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got response with result %h, expected none", resp_result);
          end else begin
            cur = exp_q.pop_front();
          end
          in_resp = 1;
        end
        check("resp_result",  resp_result,          cur.result);
        check("resp_tag",     32'(resp_tag),        32'(cur.tag));
        check("resp_fflags",  32'(resp_fflags),     32'(cur.fflags));
        check("resp_illegal", 32'(resp_illegal),    32'(cur.illegal));
        check("resp_timeout", 32'(resp_timeout),    32'(cur.timeout));
        if (resp_ready) begin
          acc_model = (fflags_clr ? 5'b0 : acc_model) |
                      ((!cur.illegal && !cur.timeout) ? cur.fflags : 5'b0);
          in_resp = 0;
        end else if (fflags_clr) begin
          acc_model = '0;
        end
      end else if (fflags_clr) begin
        acc_model = '0;
      end
    end
  end

  // Drive a request and push its expected response. Called at posedge+1.
  task automatic prep(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [1:0] op, input logic [2:0] rm, input logic [2:0] frm,
                      input logic [TW-1:0] tag, input bit hang, input int lat, input bit nx);
    logic [2:0] eff;
    bit         ill;
    exp_t       e;
    eff = (rm == 3'b111) ? frm : rm;
    ill = (eff > 3'b100);
    e.tag     = tag;
    e.illegal = ill;
    e.timeout = !ill && hang;
    e.result  = ill ? 32'h0 : (hang ? NAN : fma_model(a, b, c, op, eff));
    e.fflags  = (ill || hang) ? 5'b0 : {4'b0, nx};
    exp_q.push_back(e);
    stub_hang = hang;
    stub_lat  = lat;
    stub_nx   = nx;
    stub_frm  = eff;
    last_ill  = ill;
    if (!ill) exp_starts++;
    req_rs1 = a; req_rs2 = b; req_rs3 = c;
    req_opcode = op; req_rm = rm; req_tag = tag; csr_frm = frm;
    req_valid = 1'b1;
  endtask

  // Wait for acceptance; ends on the negedge of the cycle after acceptance.
  task automatic accept(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        $display("FAIL accept_timeout: req_ready still %0d after 200 cycles, expected 1", req_ready);
        $fatal(1, "request never accepted");
      end
    end while (!req_ready);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
    req_rm = 3'($urandom); csr_frm = 3'($urandom); req_tag = TW'($urandom);
    @(negedge clk);
    check("fma_start_cycle1", 32'(fma_start), 32'(!last_ill));
    check("resp_valid_cycle1", 32'(resp_valid), 32'(last_ill));
  endtask

  task automatic wait_resp(input int exp_n);
    int n = 0;
    while (!resp_valid) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL resp_wait_timeout: resp_valid still 0 after 200 cycles, expected 1");
        $fatal(1, "response never arrived");
      end
    end
    check("resp_latency", 32'(n), 32'(exp_n));
  endtask

  task automatic respond(input int d, input bit clr);
    @(posedge clk); #1;
    repeat (d) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    fflags_clr = clr;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    fflags_clr = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [1:0] op, input logic [2:0] rm, input logic [2:0] frm,
                        input logic [TW-1:0] tag, input bit hang, input int lat,
                        input bit nx, input int d, input bit clr);
    int w;
    bit ill;
    prep(a, b, c, op, rm, frm, tag, hang, lat, nx);
    ill = last_ill;
    accept(w);
    wait_resp(ill ? 0 : (hang ? TO + 1 : lat + 1));
    respond(d, clr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_fma_start",  32'(fma_start),  32'd0);
    check("rst_fflags_acc", 32'(fflags_acc), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Known FMA vector, static RNE.
    run_op(32'h3FC0_0000, 32'h4000_0000, 32'h3F80_0000, 2'b00, 3'b000, 3'b010, 5'd3, 0, 3, 0, 0, 0);
    // Dynamic rm resolving to RTZ.
    run_op($urandom, $urandom, $urandom, 2'b01, 3'b111, 3'b001, 5'd7, 0, 4, 0, 1, 0);
    // Inexact result sets the accumulator.
    run_op($urandom, $urandom, $urandom, 2'b10, 3'b011, 3'b000, 5'd9, 0, 2, 1, 0, 0);
    // Dynamic rm resolving to reserved 110: illegal, accumulator untouched.
    run_op($urandom, $urandom, $urandom, 2'b11, 3'b111, 3'b110, 5'd11, 0, 2, 1, 0, 0);
    // Static reserved 101.
    run_op($urandom, $urandom, $urandom, 2'b00, 3'b101, 3'b000, 5'd12, 0, 2, 1, 2, 0);

    // Back-pressure with a new request waiting during the stall.
    prep($urandom, $urandom, $urandom, 2'b01, 3'b100, 3'b000, 5'd14, 0, 2, 1);
    accept(w);
    wait_resp(3);
    @(posedge clk); #1;
    prep($urandom, $urandom, $urandom, 2'b10, 3'b010, 3'b000, 5'd15, 0, 1, 0);
    repeat (5) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    accept(w);
    check("accept_after_handshake", 32'(w), 32'd1);
    wait_resp(2);
    respond(0, 0);

    // FMA never completes: timeout after TO wait cycles, late done ignored.
    run_op($urandom, $urandom, $urandom, 2'b00, 3'b000, 3'b000, 5'd17, 1, 1, 0, 5, 0);
    // Done on the last wait cycle beats the timeout.
    run_op($urandom, $urandom, $urandom, 2'b11, 3'b001, 3'b000, 5'd18, 0, TO, 1, 0, 0);
    // Clear on the handshake of an inexact op keeps only the new flag.
    run_op($urandom, $urandom, $urandom, 2'b00, 3'b000, 3'b000, 5'd19, 0, 2, 1, 0, 1);
    check("acc_after_clr_hs", 32'(fflags_acc), 32'd1);
    // Clear alone.
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk);
    check("acc_after_clr", 32'(fflags_acc), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, $urandom, 2'($urandom), 3'($urandom), 3'($urandom),
             TW'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(1, TO),
             1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of WAIT.
    run_op($urandom, $urandom, $urandom, 2'b00, 3'b000, 3'b000, 5'd21, 0, 2, 1, 0, 0);
    prep(32'h1234_5678, $urandom, $urandom, 2'b01, 3'b001, 3'b000, 5'd22, 0, 10, 1);
    accept(w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_fma_start",  32'(fma_start),  32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready",  32'(req_ready),  32'd1);
    check("midrst_fma_rs1",    fma_rs1,         32'd0);
    check("midrst_fma_frm",    32'(fma_frm),    32'd0);
    check("midrst_fflags_acc", 32'(fflags_acc), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op($urandom, $urandom, $urandom, 2'b10, 3'b100, 3'b000, 5'd23, 0, 3, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("fma_start_count", 32'(starts), 32'(exp_starts));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
